// File: rtl/mole_round_scheduler.sv
// -----------------------------------------------------------------------------
// mole_round_scheduler
//
// Sequences one round of the whac-a-mole game at a time. On request from the
// game FSM it asks the RNG for a value, picks a mole that differs from the
// previous one, lights the matching LED, runs the level-dependent hit window
// and reports expiry back to the FSM. Misses cost one life; the last miss
// ends the game.
//
// Optional feature (macro MOLE_SPEEDUP_EN): every 8th hit shrinks the hit
// window by STEP_MS, floored at MIN_MS. With the macro undefined the window
// stays at the level value for the whole game.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   level_valid    in   one-cycle pulse: latch level and start a game
//   level          in   [1:0] difficulty select
//   ready_for_mole in   FSM waits for a mole
//   timeout_start  in   FSM has a mole up; falling edge = hit
//   rng_value      in   [7:0] random value
//   rng_valid      in   rng_value valid this cycle
//   rng_req        out  request to the RNG (only in REQ)
//   rng_ready      out  one-cycle pulse: mole chosen, window armed
//   switches       in   [NUM_MOLES-1:0] debounced switches
//   switchx        out  switch under the lit mole is pressed (combinational)
//   mole_onehot    out  [NUM_MOLES-1:0] LED drive, zero when no mole is up
//   timeout        out  1 = window open, 0 = expired / idle
//   lives_left     out  [3:0] remaining lives
//   game_over      out  high in GAMEOVER
// -----------------------------------------------------------------------------
module mole_round_scheduler #(
    parameter int NUM_MOLES = 4,
    parameter int TICK_DIV  = 50000,
    parameter int EASY_MS   = 1500,
    parameter int MED_MS    = 1000,
    parameter int HARD_MS   = 600,
    parameter int LIVES     = 3,
    parameter int STEP_MS   = 50,
    parameter int MIN_MS    = 200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 level_valid,
    input  logic [1:0]           level,
    input  logic                 ready_for_mole,
    input  logic                 timeout_start,
    input  logic [7:0]           rng_value,
    input  logic                 rng_valid,
    output logic                 rng_req,
    output logic                 rng_ready,
    input  logic [NUM_MOLES-1:0] switches,
    output logic                 switchx,
    output logic [NUM_MOLES-1:0] mole_onehot,
    output logic                 timeout,
    output logic [3:0]           lives_left,
    output logic                 game_over
);

    localparam int IDX_W = $clog2(NUM_MOLES);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MS_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_REQ,
        S_PRESENT,
        S_WINDOW,
        S_EXPIRE,
        S_GAMEOVER
    } state_t;

    state_t               state, state_nxt;
    logic                 rng_ready_nxt;
    logic [NUM_MOLES-1:0] mole_nxt;
    logic                 timeout_nxt;
    logic [3:0]           lives_nxt;
    logic                 over_nxt;
    logic [IDX_W-1:0]     prev_idx, prev_nxt;
    logic [PRE_W-1:0]     prescaler, pre_nxt;
    logic [MS_W-1:0]      win_cnt, cnt_nxt;
    logic [MS_W-1:0]      window_ms, win_ms_nxt;
    logic                 ts_q;       // timeout_start one cycle ago
    logic                 sw_hit_q;   // switch hit seen while window was open
    logic                 hit;

    logic [IDX_W-1:0]     raw_idx;
    logic [IDX_W-1:0]     pick_idx;
    logic [MS_W-1:0]      level_ms;
    logic                 tick_wrap;
    logic                 ts_fall;

`ifdef MOLE_SPEEDUP_EN
    logic [2:0]           hit_cnt, hit_cnt_nxt;
    logic [MS_W-1:0]      shrunk_ms;
`endif

    // NUM_MOLES is a power of two, so mod is just the low bits.
    assign raw_idx  = rng_value[IDX_W-1:0];
    // Never repeat the previous mole; the +1 wraps naturally in IDX_W bits.
    assign pick_idx = (raw_idx == prev_idx) ? raw_idx + 1'b1 : raw_idx;

    assign tick_wrap = (prescaler == PRE_W'(TICK_DIV - 1));
    assign ts_fall   = ts_q & ~timeout_start;

    assign rng_req = (state == S_REQ);
    assign switchx = |(switches & mole_onehot);

    always_comb begin
        case (level)
            2'd0:    level_ms = MS_W'(EASY_MS);
            2'd1:    level_ms = MS_W'(MED_MS);
            default: level_ms = MS_W'(HARD_MS);
        endcase
    end

`ifdef MOLE_SPEEDUP_EN
    // Compare before subtracting so the window can never wrap below zero.
    assign shrunk_ms = (window_ms >= MS_W'(MIN_MS + STEP_MS))
                     ? window_ms - MS_W'(STEP_MS) : MS_W'(MIN_MS);
`endif

    // NOTE: every signal gets its default before the case statement so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        rng_ready_nxt = 1'b0;
        mole_nxt      = mole_onehot;
        timeout_nxt   = timeout;
        lives_nxt     = lives_left;
        over_nxt      = game_over;
        prev_nxt      = prev_idx;
        pre_nxt       = prescaler;
        cnt_nxt       = win_cnt;
        win_ms_nxt    = window_ms;
        hit           = 1'b0;
`ifdef MOLE_SPEEDUP_EN
        hit_cnt_nxt   = hit_cnt;
`endif

        case (state)
            S_IDLE, S_GAMEOVER: begin
                if (level_valid) begin
                    win_ms_nxt = level_ms;
                    lives_nxt  = 4'(LIVES);
                    over_nxt   = 1'b0;
                    timeout_nxt = 1'b0;
`ifdef MOLE_SPEEDUP_EN
                    hit_cnt_nxt = 3'd0;
`endif
                    state_nxt  = S_ARMED;
                end
            end

            S_ARMED: begin
                if (ready_for_mole) state_nxt = S_REQ;
            end

            S_REQ: begin
                // FSM withdrew its request (e.g. it was reset): give up.
                if (!ready_for_mole) begin
                    state_nxt = S_ARMED;
                end else if (rng_valid) begin
                    prev_nxt      = pick_idx;
                    mole_nxt      = NUM_MOLES'(1) << pick_idx;
                    cnt_nxt       = window_ms;
                    pre_nxt       = '0;
                    timeout_nxt   = 1'b1;
                    rng_ready_nxt = 1'b1;
                    state_nxt     = S_PRESENT;
                end
            end

            S_PRESENT, S_WINDOW: begin
                state_nxt = S_WINDOW;
                pre_nxt   = tick_wrap ? '0 : prescaler + 1'b1;
                if (state == S_WINDOW && ts_fall && timeout) begin
                    hit         = 1'b1;
                    mole_nxt    = '0;
                    timeout_nxt = 1'b0;
                    state_nxt   = S_ARMED;
                end else if (tick_wrap) begin
                    // Close the window on the wrap that would take the count
                    // to zero, so timeout stays high for exactly ms ticks.
                    if (win_cnt <= MS_W'(1)) begin
                        cnt_nxt     = '0;
                        timeout_nxt = 1'b0;
                        state_nxt   = S_EXPIRE;
                    end else begin
                        cnt_nxt = win_cnt - 1'b1;
                    end
                end
            end

            S_EXPIRE: begin
                mole_nxt = '0;
                // A switch press in the last open cycle wins over expiry,
                // matching the FSM which samples switchx with timeout=1.
                if (sw_hit_q) begin
                    hit       = 1'b1;
                    state_nxt = S_ARMED;
                end else if (lives_left <= 4'd1) begin
                    lives_nxt = 4'd0;
                    over_nxt  = 1'b1;
                    state_nxt = S_GAMEOVER;
                end else begin
                    lives_nxt = lives_left - 4'd1;
                    state_nxt = S_ARMED;
                end
            end

            default: state_nxt = S_IDLE;
        endcase

`ifdef MOLE_SPEEDUP_EN
        if (hit) begin
            hit_cnt_nxt = hit_cnt + 3'd1;
            if (hit_cnt == 3'd7) win_ms_nxt = shrunk_ms;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rng_ready   <= 1'b0;
            mole_onehot <= '0;
            timeout     <= 1'b0;
            lives_left  <= 4'd0;
            game_over   <= 1'b0;
            prev_idx    <= '0;
            prescaler   <= '0;
            win_cnt     <= '0;
            window_ms   <= '0;
            ts_q        <= 1'b0;
            sw_hit_q    <= 1'b0;
        end else begin
            state       <= state_nxt;
            rng_ready   <= rng_ready_nxt;
            mole_onehot <= mole_nxt;
            timeout     <= timeout_nxt;
            lives_left  <= lives_nxt;
            game_over   <= over_nxt;
            prev_idx    <= prev_nxt;
            prescaler   <= pre_nxt;
            win_cnt     <= cnt_nxt;
            window_ms   <= win_ms_nxt;
            ts_q        <= timeout_start;
            sw_hit_q    <= switchx & timeout;
        end
    end

`ifdef MOLE_SPEEDUP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hit_cnt <= 3'd0;
        else        hit_cnt <= hit_cnt_nxt;
    end

    logic unused_bits;
    assign unused_bits = ^rng_value[7:IDX_W];
`else
    logic unused_bits;
    assign unused_bits = ^{rng_value[7:IDX_W], hit, 1'(STEP_MS), 1'(MIN_MS)};
`endif

endmodule

// File: tb/tb_mole_round_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mole_round_scheduler
//
// Emulates the game FSM and the RNG around mole_round_scheduler and checks
// every round against a behavioural model of the game (previous mole, lives,
// current window length in ms, hit count). Small timing parameters keep the
// windows a few dozen cycles long.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mole_round_scheduler;

    localparam int N     = 4;
    localparam int TD    = 4;
    localparam int EASY  = 3;
    localparam int MED   = 5;
    localparam int HARD  = 2;
    localparam int LIVES = 3;
    localparam int STEP  = 1;
    localparam int MINMS = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         level_valid;
    logic [1:0]   level;
    logic         ready_for_mole;
    logic         timeout_start;
    logic [7:0]   rng_value;
    logic         rng_valid;
    logic         rng_req;
    logic         rng_ready;
    logic [N-1:0] switches;
    logic         switchx;
    logic [N-1:0] mole_onehot;
    logic         timeout;
    logic [3:0]   lives_left;
    logic         game_over;

    int vectors = 0;
    int errors  = 0;

    // Game model
    int m_prev, m_lives, m_ms, m_hits;
    bit m_over, m_accept;

    always #5 clk = ~clk;

    mole_round_scheduler #(
        .NUM_MOLES(N), .TICK_DIV(TD), .EASY_MS(EASY), .MED_MS(MED),
        .HARD_MS(HARD), .LIVES(LIVES), .STEP_MS(STEP), .MIN_MS(MINMS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .level_valid(level_valid), .level(level),
        .ready_for_mole(ready_for_mole), .timeout_start(timeout_start),
        .rng_value(rng_value), .rng_valid(rng_valid), .rng_req(rng_req),
        .rng_ready(rng_ready), .switches(switches), .switchx(switchx),
        .mole_onehot(mole_onehot), .timeout(timeout), .lives_left(lives_left),
        .game_over(game_over)
    );

    // ---------------- model ----------------
    task automatic model_reset();
        m_prev = 0; m_lives = 0; m_ms = 0; m_hits = 0;
        m_over = 0; m_accept = 1;
    endtask

    function automatic int pick(input int rv);
        int idx;
        idx = rv % N;
        if (idx == m_prev) idx = (idx + 1) % N;
        return idx;
    endfunction

    task automatic model_hit();
`ifdef MOLE_SPEEDUP_EN
        m_hits = (m_hits + 1) % 8;
        if (m_hits == 0) m_ms = (m_ms - STEP >= MINMS) ? m_ms - STEP : MINMS;
`endif
    endtask

    task automatic model_miss();
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        if (m_lives == 0) begin m_over = 1; m_accept = 1; end
    endtask

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; level_valid = 0; ready_for_mole = 0; timeout_start = 0;
        rng_valid = 0; switches = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Pulse level_valid; the model decides whether it is accepted.
    task automatic start_game(input int lvl);
        level_valid = 1'b1; level = 2'(lvl);
        @(negedge clk);
        level_valid = 1'b0;
        if (m_accept) begin
            m_ms = (lvl == 0) ? EASY : (lvl == 1) ? MED : HARD;
            m_lives = LIVES; m_over = 0; m_hits = 0; m_accept = 0;
        end
        vectors++;
        if (lives_left !== 4'(m_lives)) begin
            errors++; $display("FAIL start_lives: got %0d expected %0d", lives_left, m_lives);
        end
        vectors++;
        if (game_over !== m_over) begin
            errors++; $display("FAIL start_game_over: got %b expected %b", game_over, m_over);
        end
    endtask

    // One round. mode: 0 miss, 1 hit at sample hit_at, 2 press in the last
    // open cycle, 3 reset at sample hit_at.
    task automatic do_round(input logic [7:0] rv, input int lat, input int mode,
                            input int hit_at);
        int           idx, w, n;
        logic [N-1:0] exp_oh;
        bit           was_reset;
        idx = pick(rv);
        exp_oh = N'(1) << idx;
        w = m_ms * TD;
        was_reset = 0;

        ready_for_mole = 1'b1;
        n = 0;
        @(negedge clk);
        while (rng_req !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        vectors++;
        if (rng_req !== 1'b1) begin
            errors++; $display("FAIL rng_req_wait: got %b expected 1", rng_req);
        end
        repeat (lat) @(negedge clk);
        rng_valid = 1'b1; rng_value = rv;
        @(negedge clk);
        rng_valid = 1'b0; ready_for_mole = 1'b0; rng_value = 8'($urandom);
        m_prev = idx;
        vectors++;
        if (rng_ready !== 1'b1 || timeout !== 1'b1 || rng_req !== 1'b0) begin
            errors++;
            $display("FAIL present_flags: got rng_ready=%b timeout=%b rng_req=%b expected 1 1 0",
                     rng_ready, timeout, rng_req);
        end
        vectors++;
        if (mole_onehot !== exp_oh) begin
            errors++; $display("FAIL present_onehot: got %b expected %b", mole_onehot, exp_oh);
        end
        timeout_start = 1'b1;
        n = 1;

        while (n <= w + 3) begin
            @(negedge clk);
            if (timeout !== 1'b1) break;
            n++;
            if (n == 2) begin
                vectors++;
                if (rng_ready !== 1'b0) begin
                    errors++; $display("FAIL rng_ready_pulse: got %b expected 0", rng_ready);
                end
            end
            if (mode == 1 && n == hit_at) begin
                switches = exp_oh;
                #1;
                vectors++;
                if (switchx !== 1'b1) begin
                    errors++; $display("FAIL switchx_on_hit: got %b expected 1", switchx);
                end
            end
            if (mode == 1 && n == hit_at + 1) timeout_start = 1'b0;
            if (mode == 2 && n == w) switches = exp_oh;
            if (mode == 3 && n == hit_at) begin
                rst_n = 1'b0;
                #1;
                vectors++;
                if ({rng_req, rng_ready, mole_onehot, timeout, lives_left, game_over} !== '0) begin
                    errors++;
                    $display("FAIL reset_mid_window: got req=%b rdy=%b mole=%b to=%b lives=%0d go=%b expected all 0",
                             rng_req, rng_ready, mole_onehot, timeout, lives_left, game_over);
                end
                was_reset = 1;
                break;
            end
        end
        switches = '0;
        timeout_start = 1'b0;

        if (was_reset) begin
            @(negedge clk);
            vectors++;
            if (lives_left !== 4'd0 || timeout !== 1'b0) begin
                errors++; $display("FAIL reset_hold: got lives=%0d timeout=%b expected 0 0",
                                   lives_left, timeout);
            end
            rst_n = 1'b1;
            model_reset();
            @(negedge clk);
        end else if (mode == 1) begin
            vectors++;
            if (n != hit_at + 1 || mole_onehot !== '0 || timeout !== 1'b0 ||
                lives_left !== 4'(m_lives)) begin
                errors++;
                $display("FAIL hit_result: got samples=%0d mole=%b timeout=%b lives=%0d expected %0d 0 0 %0d",
                         n, mole_onehot, timeout, lives_left, hit_at + 1, m_lives);
            end
            model_hit();
        end else begin
            vectors++;
            if (n < w - 1 || n > w + 1) begin
                errors++; $display("FAIL window_length: got %0d cycles expected %0d", n, w);
            end
            @(negedge clk);
            if (mode == 2) model_hit(); else model_miss();
            vectors++;
            if (mole_onehot !== '0 || lives_left !== 4'(m_lives) || game_over !== m_over ||
                timeout !== 1'b0) begin
                errors++;
                $display("FAIL after_expire: got mole=%b lives=%0d go=%b timeout=%b expected 0 %0d %b 0",
                         mole_onehot, lives_left, game_over, timeout, m_lives, m_over);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; level_valid = 0; level = 0; ready_for_mole = 1;
        timeout_start = 1; rng_value = 8'hff; rng_valid = 1; switches = '1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rng_req, rng_ready, mole_onehot, timeout, lives_left, game_over, switchx} !== '0) begin
            errors++;
            $display("FAIL reset_values: got req=%b rdy=%b mole=%b to=%b lives=%0d go=%b sx=%b expected all 0",
                     rng_req, rng_ready, mole_onehot, timeout, lives_left, game_over, switchx);
        end
        ready_for_mole = 0; timeout_start = 0; rng_valid = 0; switches = '0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_first_window();
        start_game(0);
        do_round(8'd5, 0, 0, 0);           // mole 0010, window 12, lives 3->2
    endtask

    task automatic test_repeat_and_hit();
        do_round(8'd6, 1, 1, 3);           // idx 2 -> 0100, hit
        do_round(8'd2, 0, 1, 5);           // idx 2 again -> 1000
        do_round(8'd1, 2, 1, 2);           // mole 0010, hit, no life lost
    endtask

    task automatic test_late_hit();
        do_round(8'($urandom), 0, 2, 0);
    endtask

    task automatic test_abandon();
        ready_for_mole = 1'b1;
        @(negedge clk);
        vectors++;
        if (rng_req !== 1'b1) begin
            errors++; $display("FAIL abandon_req_up: got %b expected 1", rng_req);
        end
        ready_for_mole = 1'b0;
        @(negedge clk);
        vectors++;
        if (rng_req !== 1'b0 || rng_ready !== 1'b0 || mole_onehot !== '0) begin
            errors++; $display("FAIL abandon: got req=%b rdy=%b mole=%b expected 0 0 0",
                               rng_req, rng_ready, mole_onehot);
        end
    endtask

    task automatic test_ignore_level();
        start_game(1);                      // ignored mid-game
        do_round(8'($urandom), 1, 0, 0);    // window still the current one
    endtask

    task automatic test_gameover();
        int guard;
        guard = 0;
        while (!m_over && guard < 20) begin
            do_round(8'($urandom), 0, 0, 0);
            guard++;
        end
        start_game(2);
        do_round(8'($urandom), 0, 0, 0);    // HARD window
    endtask

    task automatic test_reset_mid_window();
        do_round(8'($urandom), 0, 3, m_ms * TD - 2);
        start_game(0);
    endtask

    task automatic test_random();
        int mode, w;
        for (int r = 0; r < 40; r++) begin
            if (m_accept) start_game($urandom_range(0, 3));
            mode = $urandom_range(0, 4);
            mode = (mode >= 2) ? 1 : (mode == 1 ? 2 : 0);
            w = m_ms * TD;
            do_round(8'($urandom), $urandom_range(0, 3), mode, $urandom_range(2, w - 2));
        end
    endtask

`ifdef MOLE_SPEEDUP_EN
    task automatic test_speedup();
        do_reset();
        start_game(1);
        for (int i = 0; i < 8; i++) do_round(8'($urandom), 0, 1, 3);
        do_round(8'($urandom), 0, 0, 0);    // MED-STEP window
        do_reset();
        start_game(2);
        for (int i = 0; i < 16; i++) do_round(8'($urandom), 0, 1, 3);
        do_round(8'($urandom), 0, 0, 0);    // clamped at MIN
    endtask
`endif

    initial begin
        test_reset();
        test_first_window();
        test_repeat_and_hit();
        test_late_hit();
        test_abandon();
        test_ignore_level();
        test_gameover();
        test_reset_mid_window();
        test_random();
`ifdef MOLE_SPEEDUP_EN
        test_speedup();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mole_round_scheduler.md
Name: mole_round_scheduler

Overview:
- Sequences each round of the whac-a-mole game. Sits between the game FSM, the RNG, the LEDs/switches and the countdown timer.
- On each FSM request, it picks a non-repeating mole from the RNG value and drives the one-hot LED.
- It runs the level-dependent hit window and feeds the FSM its `rng_ready`, `switchx` and `timeout` inputs.
- It counts lives and stops the game on the last miss.

Parameters:
- NUM_MOLES, 4: number of mole LEDs/switches; power of two, 2..16.
- TICK_DIV, 50000: clk cycles per 1 ms tick (50 MHz).
- EASY_MS, 1500: hit window for level 0, in ms.
- MED_MS, 1000: hit window for level 1, in ms.
- HARD_MS, 600: hit window for levels 2 and 3, in ms.
- LIVES, 3: misses allowed before game over; 1..15.
- STEP_MS, 50: window reduction per speed-up step (optional feature only).
- MIN_MS, 200: window floor (optional feature only).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- level_valid, in, 1: one-cycle pulse; latches `level` and starts a game.
- level, in, 2: difficulty select.
- ready_for_mole, in, 1: from FSM; high while it waits for a mole.
- timeout_start, in, 1: from FSM; high while a mole is up.
- rng_value, in, 8: random value.
- rng_valid, in, 1: `rng_value` is valid this cycle.
- rng_req, out, 1: request to the RNG.
- rng_ready, out, 1: to FSM; mole is chosen and the window is armed.
- switches, in, NUM_MOLES: synchronised, debounced mole switches.
- switchx, out, 1: to FSM; `|(switches & mole_onehot)`, combinational.
- mole_onehot, out, NUM_MOLES: LED drive; all zero when no mole is up.
- timeout, out, 1: to FSM; 1 = window still open, 0 = expired.
- lives_left, out, 4: remaining lives.
- game_over, out, 1: high in GAMEOVER.

Behaviour:
- Reset (async, while rst_n=0): state IDLE, rng_req=0, rng_ready=0, mole_onehot=0, timeout=0, lives_left=0, game_over=0, prev_idx=0, prescaler=0, window counter=0.
- IDLE: on level_valid, latch the window: level 0 -> EASY_MS, 1 -> MED_MS, 2/3 -> HARD_MS. Load lives_left=LIVES, go to ARMED.
- ARMED: when ready_for_mole=1, go to REQ.
- REQ: hold rng_req=1 until rng_valid=1 (the request/valid handshake; may be the same cycle). Compute idx = rng_value mod NUM_MOLES. If idx==prev_idx, use (idx+1) mod NUM_MOLES instead. Go to PRESENT.
- PRESENT (1 cycle), all registered together:
  - mole_onehot = 1<<idx, prev_idx=idx.
  - Window counter loaded with the latched ms value, prescaler cleared.
  - timeout=1 and rng_ready=1.
  - Go to WINDOW.
  - timeout is already 1 in the cycle the FSM first sees rng_ready=1.
- WINDOW:
  - Prescaler counts 0..TICK_DIV-1. On wrap, the window counter decrements by 1.
  - Counter reaches 0: timeout=0 next cycle, go to EXPIRE.
  - timeout_start falls while timeout=1: this is a hit. mole_onehot=0, timeout=0, return to ARMED.
- Hit and expiry in the same cycle:
  - switchx=1 and timeout=1 in the same cycle counts as a hit, matching FSM priority.
  - Expiry is only declared once timeout has been driven 0.
- EXPIRE (1 cycle): mole_onehot=0, lives_left decrements by exactly 1. If the result is 0, go to GAMEOVER; otherwise go to ARMED.
- GAMEOVER: game_over=1, mole_onehot=0, timeout=0. A new level_valid reloads lives and the window, clears game_over and goes to ARMED.
- level_valid outside IDLE/GAMEOVER is ignored.
- rng_ready is a single-cycle pulse. rng_req never asserts outside REQ.
- Window is exactly ms × TICK_DIV cycles (±1) from PRESENT to timeout falling.
- If ready_for_mole drops in REQ (FSM reset), abandon the request and return to ARMED.
- Reset mid-window clears everything immediately; no life is lost.
- Counters must not underflow: the window counter saturates at 0, lives_left saturates at 0.

Optional Feature:
MOLE_SPEEDUP_EN:
- Defined:
  - A 3-bit hit counter increments on each hit and clears on entry from IDLE/GAMEOVER.
  - On each wrap to 0 (every 8th hit), the latched window shrinks by STEP_MS, floored at MIN_MS. Applies from the next PRESENT.
  - Misses do not reset the hit counter.
- Undefined: the window stays fixed at the level value for the whole game; no hit counter exists.

Test Plan:
- TICK_DIV=4, EASY_MS=3, level_valid with level=0, ready_for_mole held, rng_value=5 on first rng_valid -> mole_onehot=4'b0010, rng_ready pulses one cycle, timeout falls 12±1 cycles after PRESENT, lives_left 3->2.
- Consecutive rng_value=6 then 2 (both idx 2) -> second mole is 4'b1000 (repeat avoided).
- Drive switches=4'b0010 during WINDOW with mole 4'b0010 -> switchx=1; FSM drops timeout_start -> mole_onehot=0, no life lost, timeout=0.
- Three consecutive expiries -> lives_left 2,1,0, game_over=1. Second level_valid (level=2) -> game_over=0, lives_left=3, window=HARD_MS.
- rst_n low during WINDOW with 2 cycles left -> all outputs at reset values immediately; no EXPIRE, lives_left=0.
- With MOLE_SPEEDUP_EN, MED_MS=300, 8 hits -> ninth window 250 ms; repeated speed-ups from HARD_MS=220 clamp at 200 ms.
